imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that fills the instruction memory with a program before the CPU starts fetching. It takes a framed byte stream from a host-side source such as a UART receiver, packs the bytes little-endian into 32-bit words and drives the instruction memory write port one word at a time. It holds the core in stall while loading and reports completion or error.

## Interface
Parameters:
- AW, default `PC_WIDTH (10): instruction-memory word-address width, from defines_bitwidth.vh.
- DEPTH, default 1024: number of memory words; equals 2**AW.

Ports:
- clka, input, 1: sole clock; all logic is on the rising edge.
- rsta, input, 1: reset, asynchronous, active-high.
- load_start, input, 1: single-cycle request to begin a load.
  - Sampled only in IDLE, DONE or ERR.
- in_valid, input, 1: byte-stream data valid.
- in_data, input, 8: byte-stream data.
- in_ready, output, 1: the loader accepts a byte on this cycle.
- we, output, 1: instruction-memory write enable, one-cycle pulse per word.
- waddr, output, AW: word address to write.
- wdata, output, 32: word to write.
- busy, output, 1: load in progress; the core is stalled while this is high.
- done, output, 1: last load finished and the checksum matched.
- err, output, 1: last load failed.

Outputs after reset: we, busy, done, err and in_ready are 0; waddr and wdata are all zeros.

## Operation
- The frame is L0, L1, then 4·N data bytes, then C.
  - N = {L1, L0} is a 16-bit word count.
  - Data words are little-endian, byte 0 = bits 7:0.
  - C is the checksum: the XOR of every preceding frame byte, including L0 and L1.
- A byte is accepted when in_valid and in_ready are both high at a rising clka edge.
- State machine (states IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR):
  - IDLE/DONE/ERR → LEN0 on load_start. Entering LEN0 clears done, err, the checksum accumulator, the word counter and the byte counter.
  - LEN0 → LEN1 when L0 is accepted.
  - LEN1 → next state when L1 is accepted, chosen as follows:
    - ERR if N > DEPTH; no writes take place.
    - CHK if N = 0.
    - DATA otherwise.
  - DATA:
    - A 2-bit byte counter shifts each accepted byte into a 32-bit assembly register at lane [8·k+7:8·k].
    - When the 4th byte is accepted, the completed word is registered to wdata, the word counter to waddr, and we is set to 1.
    - The word counter then increments. The machine moves to CHK after word N−1.
  - CHK → DONE if the accepted byte equals the accumulated XOR, else → ERR.
- in_ready = 1 exactly in LEN0, LEN1, DATA and CHK.
- busy = 1 in every state except IDLE, DONE and ERR.
- done = 1 in DONE only; err = 1 in ERR only. Both hold until the next load_start.
- Word counter width:
  - The word counter is AW+1 bits wide, so that N = DEPTH is reachable.
  - waddr = counter[AW-1:0]; it never wraps within a legal frame.
- load_start is ignored while busy.
- Memory contents are not touched by reset or error. Words already written stay written.

## Timing
- There is no back-pressure on the memory side. in_ready never drops inside a frame, so the stream may run at one byte per cycle.
- we is asserted in the cycle after the edge that accepted the 4th byte of a word, for exactly one cycle. waddr and wdata are valid in that same cycle.
- Successive we pulses are at least 4 cycles apart.
- waddr and wdata hold their last values while we is 0.
- The last write (if N > 0) happens in the same cycle that CHK is entered. The checksum byte can therefore be accepted no earlier than one cycle later.
- DONE or ERR is visible in the cycle after the C edge, or after the L1 edge for the N > DEPTH case. busy falls in the same cycle.
- rsta asserted mid-frame:
  - Immediately forces IDLE and the reset output values.
  - Any partial word is discarded and no we is issued.
  - The source must restart the frame after load_start.
- load_start arriving together with in_valid: the byte is not accepted on that edge, because in_ready is 0 outside the frame states.

## Structure
- The state encoding (localparams for the 7 states) and the frame constants go in a shared package/header. The frame constants are the length-field width (16) and the bytes per word (4).
- defines_bitwidth.vh supplies `PC_WIDTH.
- One natural sub-module is imem_word_packer: the byte counter, the assembly register and the word-complete strobe.
- The FSM, counters and checksum stay in imem_loader.
- The top level instantiates imem_loader next to inst_mem, with we/waddr/wdata connected to the inst_mem write port.

## Test plan
- N=2, bytes 02 00 | 78 56 34 12 | EF BE AD DE | C=XOR, streamed back-to-back:
  - Writes 0x12345678 @0, then 0xDEADBEEF @1.
  - done=1, err=0.
  - busy high from LEN0 until the cycle after C.
- Same frame with the checksum byte flipped:
  - Both writes occur.
  - err=1, done=0.
  - A subsequent load_start clears err.
- N=0, bytes 00 00 00 → no we, done=1.
- N=1025 (01 04) → err=1 immediately after L1, no we, and in_ready=0 from then on.
- N=1024 with random words and in_valid gapped randomly:
  - Exactly 1024 we pulses on addresses 0..1023 in order, with no repeats.
  - Final done=1.
  - Readback via inst_mem matches the data sent.
- rsta pulsed after 6 bytes of an N=2 frame:
  - Outputs return to reset values; only word 0 is written.
  - A fresh full frame then completes with done=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the boot-time instruction loader.
package imem_loader_pkg;

    // Default instruction-memory word-address width (program counter width).
    localparam int PC_WIDTH = 10;

    // Frame layout constants: 16-bit word-count field, 4 bytes per word.
    localparam int LEN_W          = 16;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = 2;

    // Loader states.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
        S_CHK  = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    // States in which a new load may be requested.
    function automatic logic is_rest_state(input state_t s);
        return (s == S_IDLE) || (s == S_DONE) || (s == S_ERR);
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words and flags the
// byte that completes a word. The completed word is presented combinationally
// together with the strobe so the loader can register it in the same edge.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_push,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_done
);

    logic [BYTE_CNT_W-1:0] r_cnt;
    // Only lanes 0..2 need storage; lane 3 comes straight from the input.
    logic [23:0]           r_asm;

    // Byte counter and assembly register; cleared at the start of each load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_asm <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
            r_asm <= '0;
        end else if (i_push) begin
            r_cnt <= r_cnt + 1'b1;
            case (r_cnt)
                2'd0:    r_asm[7:0]   <= i_byte;
                2'd1:    r_asm[15:8]  <= i_byte;
                2'd2:    r_asm[23:16] <= i_byte;
                default: r_asm        <= r_asm;
            endcase
        end
    end

    assign o_word_done = i_push && (r_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
    assign o_word      = {i_byte, r_asm};

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: parses a framed byte stream (length, data words,
// XOR checksum) and writes the words into instruction memory while holding
// the core stalled through busy.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int AW    = PC_WIDTH,
    parameter int DEPTH = 1024
) (
    input  logic          clka,
    input  logic          rsta,
    input  logic          load_start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t             r_state;
    logic               r_in_ready;
    logic               r_we;
    logic [AW-1:0]      r_waddr;
    logic [31:0]        r_wdata;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [7:0]         r_chk;
    logic [LEN_W-1:0]   r_len;
    logic [AW:0]        r_wcnt;

    logic               w_accept;
    logic               w_start;
    logic               w_push;
    logic [LEN_W-1:0]   w_len;
    logic [AW:0]        w_wcnt_next;
    logic [31:0]        w_word;
    logic               w_word_done;

    // A byte moves only when the source offers it and we advertise ready.
    assign w_accept    = in_valid && r_in_ready;
    assign w_start     = load_start && is_rest_state(r_state);
    assign w_push      = w_accept && (r_state == S_DATA);
    assign w_len       = {in_data, r_len[7:0]};
    assign w_wcnt_next = r_wcnt + 1'b1;

    imem_word_packer u_packer (
        .clk         (clka),
        .rst         (rsta),
        .i_clear     (w_start),
        .i_push      (w_push),
        .i_byte      (in_data),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    // Frame state machine with registered status, handshake and write-port outputs.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_chk      <= '0;
            r_len      <= '0;
            r_wcnt     <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (w_start) begin
                        r_state    <= S_LEN0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_chk      <= '0;
                        r_wcnt     <= '0;
                    end
                end
                S_LEN0: begin
                    if (w_accept) begin
                        r_len   <= {8'h00, in_data};
                        r_chk   <= r_chk ^ in_data;
                        r_state <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (w_accept) begin
                        r_len <= w_len;
                        r_chk <= r_chk ^ in_data;
                        if ({16'h0000, w_len} > DEPTH) begin
                            // Oversized program: reject before touching memory.
                            r_state    <= S_ERR;
                            r_err      <= 1'b1;
                            r_busy     <= 1'b0;
                            r_in_ready <= 1'b0;
                        end else if (w_len == '0) begin
                            r_state <= S_CHK;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_chk <= r_chk ^ in_data;
                        if (w_word_done) begin
                            r_we    <= 1'b1;
                            r_waddr <= r_wcnt[AW-1:0];
                            r_wdata <= w_word;
                            r_wcnt  <= w_wcnt_next;
                            if (LEN_W'(w_wcnt_next) == r_len) begin
                                r_state <= S_CHK;
                            end
                        end
                    end
                end
                S_CHK: begin
                    if (w_accept) begin
                        r_busy     <= 1'b0;
                        r_in_ready <= 1'b0;
                        if (in_data == r_chk) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign we       = r_we;
    assign waddr    = r_waddr;
    assign wdata    = r_wdata;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of whole frames with expected outcomes,
// a large gapped frame, and a mid-frame reset sequence.
module tb_imem_loader;

    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          clka;
    logic          rsta;
    logic          load_start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          busy;
    logic          done;
    logic          err;

    imem_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clka       (clka),
        .rsta       (rsta),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Clock and watchdog.
    initial clka = 1'b0;
    always #5 clka = ~clka;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_writes = 0;
    int last_we_cyc = 0;

    logic [AW+31:0] exp_q[$];
    logic [AW+31:0] mon_e;
    logic [31:0]    mem  [DEPTH];
    logic [31:0]    sent [DEPTH];

    typedef struct packed {
        logic [7:0]  n_bytes;
        logic [95:0] bytes;
        logic [1:0]  exp_writes;
        logic        exp_done;
        logic        exp_err;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vec [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    always @(posedge clka) cyc++;

    // Write-port monitor: every write must match the next expected {addr, data}.
    always @(negedge clka) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%h expected no write", waddr, wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write", 64'({waddr, wdata}), 64'(mon_e));
            end
            if (n_writes > 0) begin
                total++;
                if (cyc - last_we_cyc < 4) begin
                    bad++;
                    $display("FAIL we_spacing: got %0d cycles expected >= 4", cyc - last_we_cyc);
                end
            end
            last_we_cyc = cyc;
            n_writes++;
            mem[waddr] = wdata;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clka);
    endtask

    // Offer one byte at a negedge and hold it until the edge that accepts it.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clka);
            t++;
        end
        if (t >= 20) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=%b expected 1", in_ready);
        end else begin
            @(negedge clka);
        end
        in_valid = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        @(negedge clka);
        load_start = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_ready", 64'(in_ready), 64'd1);
        check("start_flags", 64'({done, err}), 64'd0);
    endtask

    task automatic run_vec(input int i);
        int base;
        start_load();
        base = n_writes;
        if (vec[i].exp_writes >= 2'd1) exp_q.push_back({10'd0, vec[i].w0});
        if (vec[i].exp_writes >= 2'd2) exp_q.push_back({10'd1, vec[i].w1});
        for (int j = 0; j < int'(vec[i].n_bytes); j++) begin
            if (j == int'(vec[i].n_bytes) - 1) check("busy_before_last", 64'(busy), 64'd1);
            send_byte(vec[i].bytes[8*j +: 8]);
        end
        check("vec_done", 64'(done), 64'(vec[i].exp_done));
        check("vec_err", 64'(err), 64'(vec[i].exp_err));
        check("vec_busy_end", 64'(busy), 64'd0);
        check("vec_ready_end", 64'(in_ready), 64'd0);
        check("vec_nwrites", 64'(n_writes - base), 64'(vec[i].exp_writes));
        check("vec_expq_empty", 64'(exp_q.size()), 64'd0);
        idle(3);
        check("vec_ready_hold", 64'(in_ready), 64'd0);
        check("vec_flags_hold", 64'({done, err}), 64'({vec[i].exp_done, vec[i].exp_err}));
    endtask

    initial begin
        int base;
        int mism;
        logic [7:0]  chk;
        logic [31:0] word;
        logic [7:0]  b;

        rsta       = 1'b1;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        idle(3);
        check("reset_ctrl", 64'({we, busy, done, err, in_ready}), 64'd0);
        check("reset_addr", 64'(waddr), 64'd0);
        check("reset_data", 64'(wdata), 64'd0);
        rsta = 1'b0;
        idle(2);

        // N=2 good frame, checksum 0x28.
        vec[0] = '{n_bytes: 8'd11, bytes: 96'h00_28_DE_AD_BE_EF_12_34_56_78_00_02,
                   exp_writes: 2'd2, exp_done: 1'b1, exp_err: 1'b0,
                   w0: 32'h12345678, w1: 32'hDEADBEEF};
        // Same frame, checksum flipped.
        vec[1] = '{n_bytes: 8'd11, bytes: 96'h00_D7_DE_AD_BE_EF_12_34_56_78_00_02,
                   exp_writes: 2'd2, exp_done: 1'b0, exp_err: 1'b1,
                   w0: 32'h12345678, w1: 32'hDEADBEEF};
        // N=0: length then checksum 0.
        vec[2] = '{n_bytes: 8'd3, bytes: 96'h000000,
                   exp_writes: 2'd0, exp_done: 1'b1, exp_err: 1'b0,
                   w0: 32'h0, w1: 32'h0};
        // N=1025: rejected right after L1.
        vec[3] = '{n_bytes: 8'd2, bytes: 96'h0401,
                   exp_writes: 2'd0, exp_done: 1'b0, exp_err: 1'b1,
                   w0: 32'h0, w1: 32'h0};

        for (int i = 0; i < 4; i++) run_vec(i);

        // Full-depth frame with random words and gapped bytes.
        start_load();
        base = n_writes;
        chk = 8'h00 ^ 8'h04;
        send_byte(8'h00);
        send_byte(8'h04);
        for (int w = 0; w < DEPTH; w++) begin
            word = $urandom;
            sent[w] = word;
            exp_q.push_back({w[AW-1:0], word});
            for (int k = 0; k < 4; k++) begin
                b = word[8*k +: 8];
                chk = chk ^ b;
                idle($urandom_range(0, 2));
                send_byte(b);
            end
        end
        check("big_busy_before_chk", 64'(busy), 64'd1);
        send_byte(chk);
        check("big_done", 64'({done, err}), 64'b10);
        check("big_nwrites", 64'(n_writes - base), 64'(DEPTH));
        check("big_last_addr", 64'(waddr), 64'(DEPTH - 1));
        check("big_last_data", 64'(wdata), 64'(sent[DEPTH-1]));
        mism = 0;
        for (int w = 0; w < DEPTH; w++) begin
            if (mem[w] !== sent[w]) mism++;
        end
        check("big_readback_mismatches", 64'(mism), 64'd0);

        // Reset after 6 bytes of an N=2 frame: only word 0 lands.
        start_load();
        base = n_writes;
        exp_q.push_back({10'd0, 32'h12345678});
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        idle(1);
        rsta = 1'b1;
        #1;
        check("rst_mid_ctrl", 64'({we, busy, done, err, in_ready}), 64'd0);
        check("rst_mid_addr_data", 64'({waddr, wdata}), 64'd0);
        idle(2);
        rsta = 1'b0;
        idle(2);
        check("rst_mid_nwrites", 64'(n_writes - base), 64'd1);
        check("rst_mid_expq", 64'(exp_q.size()), 64'd0);
        run_vec(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
